// File: rtl/i2s_tx.sv
// I2S (Philips) transmitter: 16-bit stereo PCM serialised MSB first, with the bit
// clock and word select derived from clk_48mhz by integer division.
module i2s_tx #(
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned SLOT_W   = 32,
    parameter int unsigned HALF_DIV = 8
) (
    input  logic                clk_48mhz,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                i2s_sclk,
    output logic                i2s_lrclk,
    output logic                i2s_sdata,
    output logic                underrun
);

    localparam int unsigned FRAME_W = 2 * SLOT_W;
    localparam int unsigned PAD_W   = SLOT_W - SAMPLE_W;
    localparam int unsigned DIV_W   = $clog2(HALF_DIV);
    localparam int unsigned BIT_W   = $clog2(FRAME_W);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0] LR_FIRST = BIT_W'(SLOT_W - 1);
    localparam logic [BIT_W-1:0] LR_LAST  = BIT_W'(FRAME_W - 2);

    logic [DIV_W-1:0]    div_cnt,   div_cnt_nxt;
    logic [BIT_W-1:0]    bit_cnt,   bit_cnt_nxt;
    logic [SAMPLE_W-1:0] buf_left,  left_nxt;
    logic [SAMPLE_W-1:0] buf_right, right_nxt;
    logic [FRAME_W-1:0]  shift_reg, shift_nxt;
    logic [FRAME_W-1:0]  frame;
    logic                sclk_nxt, lrclk_nxt, sdata_nxt, underrun_nxt, ready_nxt;
    logic                tick;

    // State register; s_ready doubles as the "holding buffer empty" flag
    always_ff @(posedge clk_48mhz) begin
        if (!reset) begin
            div_cnt   <= '0;
            bit_cnt   <= BIT_LAST;
            buf_left  <= '0;
            buf_right <= '0;
            shift_reg <= '0;
            i2s_sclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
            s_ready   <= 1'b1;
        end else begin
            div_cnt   <= div_cnt_nxt;
            bit_cnt   <= bit_cnt_nxt;
            buf_left  <= left_nxt;
            buf_right <= right_nxt;
            shift_reg <= shift_nxt;
            i2s_sclk  <= sclk_nxt;
            i2s_lrclk <= lrclk_nxt;
            i2s_sdata <= sdata_nxt;
            underrun  <= underrun_nxt;
            s_ready   <= ready_nxt;
        end
    end

    // Next-state logic: divider, bit counter, frame load and handshake
    always_comb begin
        div_cnt_nxt  = div_cnt + DIV_W'(1);
        bit_cnt_nxt  = bit_cnt;
        left_nxt     = buf_left;
        right_nxt    = buf_right;
        shift_nxt    = shift_reg;
        frame        = shift_reg;
        sclk_nxt     = i2s_sclk;
        lrclk_nxt    = i2s_lrclk;
        sdata_nxt    = i2s_sdata;
        underrun_nxt = 1'b0;
        ready_nxt    = s_ready;
        tick         = 1'b0;

        if (div_cnt == DIV_LAST) begin
            div_cnt_nxt = '0;
            sclk_nxt    = ~i2s_sclk;
            tick        = i2s_sclk;
        end

        if (tick) begin
            bit_cnt_nxt = (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
            lrclk_nxt   = (bit_cnt_nxt >= LR_FIRST) && (bit_cnt_nxt <= LR_LAST);
            if (bit_cnt == BIT_LAST) begin
                if (!s_ready) begin
                    frame     = {(SLOT_W'(buf_left) << PAD_W), (SLOT_W'(buf_right) << PAD_W)};
                    ready_nxt = 1'b1;
                end else begin
                    frame        = '0;
                    underrun_nxt = 1'b1;
                end
            end
            sdata_nxt = frame[FRAME_W-1];
            shift_nxt = frame << 1;
        end

        // A transfer on an underrun load cycle is held for the following frame
        if (s_valid && s_ready) begin
            ready_nxt = 1'b0;
            left_nxt  = s_left;
            right_nxt = s_right;
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Self-checking bench for i2s_tx: a cycle-time reference model derived from the
// divider/frame arithmetic, plus frame capture on sclk rising edges.
module tb_i2s_tx;

    localparam int H     = 8;
    localparam int SLOT  = 32;
    localparam int FRAME = 64;
    localparam logic [63:0] LR_WORD = 64'h0000_0001_FFFF_FFFE;

    logic        clk_48mhz = 1'b0;
    logic        reset;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_left;
    logic [15:0] s_right;
    logic        i2s_sclk;
    logic        i2s_lrclk;
    logic        i2s_sdata;
    logic        underrun;

    i2s_tx #(.SAMPLE_W(16), .SLOT_W(SLOT), .HALF_DIV(H)) dut (
        .clk_48mhz (clk_48mhz),
        .reset     (reset),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_left    (s_left),
        .s_right   (s_right),
        .i2s_sclk  (i2s_sclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .underrun  (underrun)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    int n_checks = 0;
    int n_err    = 0;

    // Reference model state, updated once per rising edge
    int          m_t       = 0;
    logic        exp_sclk  = 1'b0;
    logic        exp_lr    = 1'b0;
    logic        exp_sd    = 1'b0;
    logic        exp_und   = 1'b0;
    logic        exp_ready = 1'b1;
    logic        m_full    = 1'b0;
    logic [15:0] m_left    = '0;
    logic [15:0] m_right   = '0;
    logic [63:0] m_frame   = '0;
    int          xfer_t[$];

    always @(posedge clk_48mhz) begin : model
        int   mb;
        logic mx;
        if (!reset) begin
            m_t = 0; exp_sclk = 0; exp_lr = 0; exp_sd = 0; exp_und = 0;
            exp_ready = 1; m_full = 0; m_frame = '0;
        end else begin
            mx = s_valid && exp_ready;
            m_t++;
            exp_sclk = ((m_t / H) % 2) == 1;
            exp_und  = 1'b0;
            if (m_t % (2 * H) == 0) begin
                mb = (m_t / (2 * H) - 1) % FRAME;
                if (mb == 0) begin
                    if (m_full) begin
                        m_frame   = {m_left, 16'h0000, m_right, 16'h0000};
                        m_full    = 1'b0;
                        exp_ready = 1'b1;
                    end else begin
                        m_frame = '0;
                        exp_und = 1'b1;
                    end
                end
                exp_sd = m_frame[FRAME-1-mb];
                exp_lr = (mb >= SLOT - 1) && (mb <= FRAME - 2);
            end
            if (mx) begin
                m_full = 1'b1; m_left = s_left; m_right = s_right;
                exp_ready = 1'b0;
                xfer_t.push_back(m_t);
            end
        end
    end

    // Capture state observed from the DUT
    int          cyc = 0, rise_cnt = 0, und_cnt = 0, dut_xfer = 0;
    int          first_rise = -1, first_fall = -1, first_und = -1;
    logic        prev_sclk = 1'b0, prev_ready = 1'b1;
    logic [63:0] cur_rx = '0, cur_lr = '0;
    logic [63:0] rx_frames[$];
    logic [63:0] rx_lr[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Advance to the next falling edge, compare against the model, capture bits
    task automatic step();
        int b;
        @(negedge clk_48mhz);
        check("sclk",     64'(i2s_sclk),  64'(exp_sclk));
        check("lrclk",    64'(i2s_lrclk), 64'(exp_lr));
        check("sdata",    64'(i2s_sdata), 64'(exp_sd));
        check("underrun", 64'(underrun),  64'(exp_und));
        check("s_ready",  64'(s_ready),   64'(exp_ready));
        if (!reset) begin
            cyc = 0; rise_cnt = 0; und_cnt = 0; dut_xfer = 0;
            first_rise = -1; first_fall = -1; first_und = -1;
            rx_frames.delete(); rx_lr.delete();
        end else begin
            cyc++;
            if (i2s_sclk && !prev_sclk) begin
                if (first_rise < 0) first_rise = cyc;
                if (rise_cnt >= 1) begin
                    b = (rise_cnt - 1) % FRAME;
                    cur_rx[63-b] = i2s_sdata;
                    cur_lr[63-b] = i2s_lrclk;
                    if (b == FRAME - 1) begin
                        rx_frames.push_back(cur_rx);
                        rx_lr.push_back(cur_lr);
                    end
                end
                rise_cnt++;
            end
            if (!i2s_sclk && prev_sclk && first_fall < 0) first_fall = cyc;
            if (underrun) begin
                und_cnt++;
                if (first_und < 0) first_und = cyc;
            end
            if (prev_ready && !s_ready) dut_xfer++;
        end
        prev_sclk  = i2s_sclk;
        prev_ready = s_ready;
    endtask

    task automatic wait_frames(input int n);
        int budget = 1300 * n;
        while (rx_frames.size() < n && budget > 0) begin
            step();
            budget--;
        end
        if (rx_frames.size() < n) check("frame_timeout", 64'(rx_frames.size()), 64'(n));
    endtask

    task automatic do_reset(input int n);
        reset = 1'b0;
        s_valid = 1'b0;
        repeat (n) step();
    endtask

    initial begin : stim
        int unsigned base;
        int          x0;
        logic [15:0] cl, cr;
        reset = 1'b0; s_valid = 1'b0; s_left = '0; s_right = '0;

        // Reset values
        do_reset(5);
        check("rst_sclk",  64'(i2s_sclk),  64'd0);
        check("rst_lrclk", 64'(i2s_lrclk), 64'd0);
        check("rst_sdata", 64'(i2s_sdata), 64'd0);
        check("rst_ready", 64'(s_ready),   64'd1);
        check("rst_und",   64'(underrun),  64'd0);

        // Single frame
        reset = 1'b1; s_valid = 1'b1; s_left = 16'hA5F0; s_right = 16'h1234;
        step();
        s_valid = 1'b0; s_left = 16'($urandom); s_right = 16'($urandom);
        wait_frames(1);
        check("first_rise", 64'(first_rise), 64'd8);
        check("first_fall", 64'(first_fall), 64'd16);
        check("sf_data", rx_frames[0], 64'hA5F0_0000_1234_0000);
        check("sf_lr",   rx_lr[0], LR_WORD);

        // Underrun with no upstream data
        do_reset(3);
        reset = 1'b1;
        repeat (2100) step();
        check("ur_count", 64'(und_cnt), 64'd3);
        check("ur_first", 64'(first_und), 64'd16);
        for (int i = 0; i < 2; i++) begin
            check("ur_data", rx_frames[i], 64'd0);
            check("ur_lr",   rx_lr[i], LR_WORD);
        end

        // Streaming with an incrementing pattern
        do_reset(2);
        reset = 1'b1; s_valid = 1'b1;
        base = $urandom;
        x0 = xfer_t.size();
        repeat (4200) begin
            s_left  = 16'(base + 2 * (xfer_t.size() - x0));
            s_right = 16'(base + 2 * (xfer_t.size() - x0) + 1);
            step();
        end
        s_valid = 1'b0;
        check("st_und",   64'(und_cnt), 64'd0);
        check("st_xfers", 64'(dut_xfer), 64'd6);
        for (int i = 0; i < 4; i++)
            check("st_data", rx_frames[i],
                  {16'(base + 2 * i), 16'h0000, 16'(base + 2 * i + 1), 16'h0000});

        // Transfer on the frame-load cycle with an empty buffer
        do_reset(2);
        reset = 1'b1;
        repeat (15) step();
        cl = 16'($urandom) | 16'h8001; cr = 16'($urandom) | 16'h0100;
        s_valid = 1'b1; s_left = cl; s_right = cr;
        step();
        s_valid = 1'b0; s_left = '0; s_right = '0;
        check("col_und",   64'(underrun), 64'd1);
        check("col_ready", 64'(s_ready),  64'd0);
        wait_frames(2);
        check("col_frame0", rx_frames[0], 64'd0);
        check("col_frame1", rx_frames[1], {cl, 16'h0000, cr, 16'h0000});

        // Reset mid-frame with a pair held
        do_reset(2);
        reset = 1'b1; s_valid = 1'b1; s_left = 16'hFFFF; s_right = 16'hFFFF;
        step();
        s_valid = 1'b0;
        while (cyc < 16) step();
        s_valid = 1'b1; s_left = 16'h7ACE; s_right = 16'hBEEF;
        step();
        s_valid = 1'b0;
        while (cyc < 346) step();
        check("mr_sclk_before",  64'(i2s_sclk), 64'd1);
        check("mr_ready_before", 64'(s_ready),  64'd0);
        reset = 1'b0;
        step();
        check("mr_sclk",  64'(i2s_sclk),  64'd0);
        check("mr_lrclk", 64'(i2s_lrclk), 64'd0);
        check("mr_sdata", 64'(i2s_sdata), 64'd0);
        check("mr_ready", 64'(s_ready),   64'd1);
        check("mr_und",   64'(underrun),  64'd0);
        step();
        reset = 1'b1;
        wait_frames(1);
        check("mr_und_first", 64'(first_und), 64'd16);
        check("mr_frame0",    rx_frames[0], 64'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
